// File: rtl/alarm_snooze_ctrl.sv
// Alarm-response sequencer: rings a pulsed buzzer on an alarm edge, handles
// snooze countdowns and a ring timeout, and pulses stop_al back upstream.
module alarm_snooze_ctrl #(
  parameter int SNOOZE_SEC  = 300,
  parameter int TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       alarm_in,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_cnt,
  output logic [8:0] snooze_remain,
  output logic       missed,
  output logic       stop_al
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam logic [2:0] MAX_CNT      = 3'(MAX_SNOOZE);
  localparam logic [8:0] SNOOZE_LOAD  = 9'(SNOOZE_SEC);
  localparam logic [8:0] TIMEOUT_LAST = 9'(TIMEOUT_SEC - 1);

  state_t     state_q, state_d;
  logic       alarm_q, alarm_d;
  logic [8:0] ring_cnt_q, ring_cnt_d;
  logic [2:0] snooze_cnt_q, snooze_cnt_d;
  logic [8:0] snooze_remain_q, snooze_remain_d;
  logic       buzzer_q, buzzer_d;
  logic       missed_q, missed_d;
  logic       stop_al_q, stop_al_d;
  logic       trigger;

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      alarm_q         <= 1'b0;
      ring_cnt_q      <= 9'd0;
      snooze_cnt_q    <= 3'd0;
      snooze_remain_q <= 9'd0;
      buzzer_q        <= 1'b0;
      missed_q        <= 1'b0;
      stop_al_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      alarm_q         <= alarm_d;
      ring_cnt_q      <= ring_cnt_d;
      snooze_cnt_q    <= snooze_cnt_d;
      snooze_remain_q <= snooze_remain_d;
      buzzer_q        <= buzzer_d;
      missed_q        <= missed_d;
      stop_al_q       <= stop_al_d;
    end
  end

  // Only a rising edge starts an event, so a flag left high upstream cannot retrigger.
  assign trigger = alarm_in & ~alarm_q;

  always_comb begin
    state_d         = state_q;
    alarm_d         = alarm_in;
    ring_cnt_d      = ring_cnt_q;
    snooze_cnt_d    = snooze_cnt_q;
    snooze_remain_d = snooze_remain_q;
    buzzer_d        = buzzer_q;
    missed_d        = missed_q;
    stop_al_d       = 1'b0;

    case (state_q)
      IDLE: begin
        buzzer_d        = 1'b0;
        snooze_remain_d = 9'd0;
        if (trigger) begin
          state_d      = RING;
          ring_cnt_d   = 9'd0;
          snooze_cnt_d = 3'd0;
          buzzer_d     = 1'b1;
          missed_d     = 1'b0;
        end else if (stop_btn) begin
          missed_d = 1'b0;
        end
      end

      RING: begin
        ring_cnt_d = ring_cnt_q + 9'd1;
        buzzer_d   = ~buzzer_q;
        if (stop_btn) begin
          state_d   = IDLE;
          stop_al_d = 1'b1;
          buzzer_d  = 1'b0;
        end else if (snooze_btn && (snooze_cnt_q < MAX_CNT)) begin
          state_d         = SNOOZE;
          snooze_cnt_d    = snooze_cnt_q + 3'd1;
          snooze_remain_d = SNOOZE_LOAD;
          buzzer_d        = 1'b0;
        end else if (ring_cnt_q == TIMEOUT_LAST) begin
          state_d   = IDLE;
          missed_d  = 1'b1;
          stop_al_d = 1'b1;
          buzzer_d  = 1'b0;
        end
      end

      SNOOZE: begin
        buzzer_d        = 1'b0;
        snooze_remain_d = snooze_remain_q - 9'd1;
        if (stop_btn) begin
          state_d         = IDLE;
          stop_al_d       = 1'b1;
          snooze_remain_d = 9'd0;
        end else if (snooze_remain_q == 9'd1) begin
          state_d         = RING;
          ring_cnt_d      = 9'd0;
          buzzer_d        = 1'b1;
          snooze_remain_d = 9'd0;
        end
      end

      default: begin
        state_d         = IDLE;
        buzzer_d        = 1'b0;
        snooze_remain_d = 9'd0;
      end
    endcase
  end

  assign buzzer        = buzzer_q;
  assign ringing       = (state_q == RING);
  assign snoozing      = (state_q == SNOOZE);
  assign snooze_cnt    = snooze_cnt_q;
  assign snooze_remain = snooze_remain_q;
  assign missed        = missed_q;
  assign stop_al       = stop_al_q;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Directed bench for alarm_snooze_ctrl with short snooze/timeout parameters so
// every expected status word below can be worked out by hand.
module tb_alarm_snooze_ctrl;

  logic       clk_1s;
  logic       reset;
  logic       alarm_in;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_cnt;
  logic [8:0] snooze_remain;
  logic       missed;
  logic       stop_al;

  int compared;
  int mismatched;

  logic [16:0] obs;
  logic [16:0] want;

  alarm_snooze_ctrl #(
    .SNOOZE_SEC (5),
    .TIMEOUT_SEC(4),
    .MAX_SNOOZE (3)
  ) dut (
    .clk_1s       (clk_1s),
    .reset        (reset),
    .alarm_in     (alarm_in),
    .snooze_btn   (snooze_btn),
    .stop_btn     (stop_btn),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .snooze_cnt   (snooze_cnt),
    .snooze_remain(snooze_remain),
    .missed       (missed),
    .stop_al      (stop_al)
  );

  initial clk_1s = 1'b0;
  always #5 clk_1s = ~clk_1s;

  // Status word order: ringing, snoozing, buzzer, missed, stop_al, snooze_cnt, snooze_remain.
  assign obs = {ringing, snoozing, buzzer, missed, stop_al, snooze_cnt, snooze_remain};

  function automatic logic [16:0] st(input logic r, input logic s, input logic b,
                                     input logic m, input logic sa,
                                     input logic [2:0] c, input logic [8:0] rem);
    return {r, s, b, m, sa, c, rem};
  endfunction

  task automatic step;
    @(posedge clk_1s);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; alarm_in = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    #2 reset = 1'b1;
    #1;
    want = st(0, 0, 0, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL reset_async: got %b want %b", obs, want); end
    step; step;
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL reset_held: got %b want %b", obs, want); end
    reset = 1'b0;
    step;
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL idle_after_reset: got %b want %b", obs, want); end
  endtask

  task automatic test_ring_stop;
    alarm_in = 1'b1;
    step;
    want = st(1, 0, 1, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL ring_entry: got %b want %b", obs, want); end
    for (int i = 1; i <= 3; i++) begin
      step;
      want = st(1, 0, (i % 2 == 0), 0, 0, 3'd0, 9'd0);
      compared++;
      if (obs !== want) begin mismatched++; $display("[TB] FAIL buzz_phase_%0d: got %b want %b", i, obs, want); end
    end
    // Stop lands on the same edge the timeout would fire; stop must win, so missed stays 0.
    stop_btn = 1'b1; alarm_in = 1'b0;
    step;
    want = st(0, 0, 0, 0, 1, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL stop_pulse: got %b want %b", obs, want); end
    stop_btn = 1'b0;
    step;
    want = st(0, 0, 0, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL stop_al_one_cycle: got %b want %b", obs, want); end
  endtask

  task automatic test_snooze;
    alarm_in = 1'b1;
    step;
    want = st(1, 0, 1, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL snz_ring_entry: got %b want %b", obs, want); end
    step;
    want = st(1, 0, 0, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL snz_ring_2nd: got %b want %b", obs, want); end
    snooze_btn = 1'b1;
    step;
    want = st(0, 1, 0, 0, 0, 3'd1, 9'd5);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL snooze_entry: got %b want %b", obs, want); end
    snooze_btn = 1'b0;
    for (int r = 4; r >= 1; r--) begin
      step;
      want = st(0, 1, 0, 0, 0, 3'd1, 9'(r));
      compared++;
      if (obs !== want) begin mismatched++; $display("[TB] FAIL snooze_remain_%0d: got %b want %b", r, obs, want); end
    end
    step;
    want = st(1, 0, 1, 0, 0, 3'd1, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL snooze_expire: got %b want %b", obs, want); end
  endtask

  task automatic test_max_snooze;
    snooze_btn = 1'b1;
    step;
    want = st(0, 1, 0, 0, 0, 3'd2, 9'd5);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL snooze2_entry: got %b want %b", obs, want); end
    snooze_btn = 1'b0;
    for (int r = 4; r >= 1; r--) begin
      step;
      want = st(0, 1, 0, 0, 0, 3'd2, 9'(r));
      compared++;
      if (obs !== want) begin mismatched++; $display("[TB] FAIL snooze2_remain_%0d: got %b want %b", r, obs, want); end
    end
    step;
    want = st(1, 0, 1, 0, 0, 3'd2, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL snooze2_expire: got %b want %b", obs, want); end
    snooze_btn = 1'b1;
    step;
    want = st(0, 1, 0, 0, 0, 3'd3, 9'd5);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL snooze3_entry: got %b want %b", obs, want); end
    step;
    want = st(0, 1, 0, 0, 0, 3'd3, 9'd4);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL snooze_btn_in_snooze: got %b want %b", obs, want); end
    snooze_btn = 1'b0;
    for (int r = 3; r >= 1; r--) begin
      step;
      want = st(0, 1, 0, 0, 0, 3'd3, 9'(r));
      compared++;
      if (obs !== want) begin mismatched++; $display("[TB] FAIL snooze3_remain_%0d: got %b want %b", r, obs, want); end
    end
    step;
    want = st(1, 0, 1, 0, 0, 3'd3, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL snooze3_expire: got %b want %b", obs, want); end
    // Snooze budget is exhausted: the held button is ignored and the ring runs to timeout.
    snooze_btn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step;
      want = st(1, 0, (i % 2 == 0), 0, 0, 3'd3, 9'd0);
      compared++;
      if (obs !== want) begin mismatched++; $display("[TB] FAIL max_snooze_ignored_%0d: got %b want %b", i, obs, want); end
    end
    step;
    want = st(0, 0, 0, 1, 1, 3'd3, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL timeout_after_max: got %b want %b", obs, want); end
    snooze_btn = 1'b0;
    step;
    want = st(0, 0, 0, 1, 0, 3'd3, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL no_retrigger_high: got %b want %b", obs, want); end
  endtask

  task automatic test_timeout;
    alarm_in = 1'b0;
    step;
    want = st(0, 0, 0, 1, 0, 3'd3, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL idle_holds_cnt: got %b want %b", obs, want); end
    alarm_in = 1'b1;
    step;
    want = st(1, 0, 1, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL retrigger_clears: got %b want %b", obs, want); end
    for (int i = 1; i <= 3; i++) begin
      step;
      want = st(1, 0, (i % 2 == 0), 0, 0, 3'd0, 9'd0);
      compared++;
      if (obs !== want) begin mismatched++; $display("[TB] FAIL to_ring_%0d: got %b want %b", i, obs, want); end
    end
    step;
    want = st(0, 0, 0, 1, 1, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL timeout: got %b want %b", obs, want); end
    alarm_in = 1'b0;
    step;
    want = st(0, 0, 0, 1, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL missed_sticky: got %b want %b", obs, want); end
    stop_btn = 1'b1;
    step;
    want = st(0, 0, 0, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL stop_clears_missed: got %b want %b", obs, want); end
    stop_btn = 1'b0;
  endtask

  task automatic test_back_to_back;
    alarm_in = 1'b1; stop_btn = 1'b1;
    step;
    want = st(1, 0, 1, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL trigger_beats_stop: got %b want %b", obs, want); end
    snooze_btn = 1'b1;
    step;
    want = st(0, 0, 0, 0, 1, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL stop_beats_snooze: got %b want %b", obs, want); end
    stop_btn = 1'b0; snooze_btn = 1'b0; alarm_in = 1'b0;
    step;
    want = st(0, 0, 0, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL stop_al_single: got %b want %b", obs, want); end
  endtask

  task automatic test_reset_mid_snooze;
    alarm_in = 1'b1;
    step;
    snooze_btn = 1'b1;
    step;
    snooze_btn = 1'b0;
    step; step;
    want = st(0, 1, 0, 0, 0, 3'd1, 9'd3);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL pre_reset_snooze: got %b want %b", obs, want); end
    #2 reset = 1'b1;
    #1;
    want = st(0, 0, 0, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL reset_async_snooze: got %b want %b", obs, want); end
    step;
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL reset_no_stop_al: got %b want %b", obs, want); end
    reset = 1'b0;
    // Reset clears the sampled alarm level, so a flag still high reads as a fresh edge.
    step;
    want = st(1, 0, 1, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL level_after_reset: got %b want %b", obs, want); end
    stop_btn = 1'b1;
    step;
    want = st(0, 0, 0, 0, 1, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL post_reset_stop: got %b want %b", obs, want); end
    stop_btn = 1'b0;
    step;
    want = st(0, 0, 0, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL held_high_no_retrigger: got %b want %b", obs, want); end
    alarm_in = 1'b0;
    step;
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL alarm_low_idle: got %b want %b", obs, want); end
    alarm_in = 1'b1;
    step;
    want = st(1, 0, 1, 0, 0, 3'd0, 9'd0);
    compared++;
    if (obs !== want) begin mismatched++; $display("[TB] FAIL fresh_edge_trigger: got %b want %b", obs, want); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset;
    test_ring_stop;
    test_snooze;
    test_max_snooze;
    test_timeout;
    test_back_to_back;
    test_reset_mid_snooze;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
